// File: rtl/executa_movimentos.sv
// executa_movimentos: plays a stored list of 3-bit movement codes to a motor executor.
// Optional motor timeout enabled by defining EXECUTA_MOVIMENTOS_TIMEOUT_EN.
// Ports:
//   clock_i       system clock, rising edge
//   reset_i       asynchronous reset, active low
//   iniciar_i     level, start executing the list
//   parar_i       level, abort and return to idle
//   mem_dado_i    movement read from memory, valid one cycle after mem_addr_o changes
//   motor_done_i  executor finished the current movement
//   mem_addr_o    movement memory read address
//   motor_cmd_o   movement code presented to the executor
//   motor_start_o one-cycle pulse to perform motor_cmd_o
//   pronto_o      one-cycle pulse when the list has finished
//   erro_o        level, motor timeout occurred
//   db_estado_o   current state code
module executa_movimentos #(
  parameter int ADDR_W  = 6,
  parameter int TIMEOUT = 50_000_000
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              iniciar_i,
  input  logic              parar_i,
  input  logic [2:0]        mem_dado_i,
  input  logic              motor_done_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [2:0]        motor_cmd_o,
  output logic              motor_start_o,
  output logic              pronto_o,
  output logic              erro_o,
  output logic [3:0]        db_estado_o
);
  typedef enum logic [3:0] {
    INICIAL    = 4'd0,
    ZERA       = 4'd1,
    LE         = 4'd2,
    DECODIFICA = 4'd3,
    DISPARA    = 4'd4,
    ESPERA     = 4'd5,
    PROXIMO    = 4'd6,
    FIM        = 4'd7,
    ERRO       = 4'd8
  } estado_t;

  estado_t           state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        cmd_q, cmd_d;
  logic              expira;

`ifdef EXECUTA_MOVIMENTOS_TIMEOUT_EN
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  // Counter is zero on the first ESPERA cycle, so expiry lands TIMEOUT cycles after entry.
  assign cnt_d  = state_q == ESPERA ? cnt_q + 1'b1 : '0;
  assign expira = state_q == ESPERA && cnt_q == CW'(TIMEOUT - 1);
  assign erro_o = state_q == ERRO;
  always_ff @(posedge clock_i or negedge reset_i)
    if (!reset_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
`else
  assign expira = 1'b0;
  assign erro_o = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cmd_d   = cmd_q;
    case (state_q)
      INICIAL:    state_d = iniciar_i ? ZERA : INICIAL;
      ZERA: begin
        addr_d  = '0;
        state_d = LE;
      end
      LE:         state_d = DECODIFICA;
      DECODIFICA: begin
        state_d = mem_dado_i == 3'b111 ? FIM : DISPARA;
        cmd_d   = mem_dado_i == 3'b111 ? cmd_q : mem_dado_i;
      end
      DISPARA:    state_d = ESPERA;
      ESPERA:     state_d = motor_done_i ? PROXIMO : expira ? ERRO : ESPERA;
      PROXIMO: begin
        state_d = &addr_q ? FIM : LE;
        addr_d  = &addr_q ? addr_q : addr_q + 1'b1;
      end
      FIM:        state_d = INICIAL;
      ERRO:       state_d = iniciar_i ? ZERA : ERRO;
      default:    state_d = INICIAL;
    endcase
    // Abort overrides every transition and freezes the datapath registers.
    if (parar_i && state_q != INICIAL) begin
      state_d = INICIAL;
      addr_d  = addr_q;
      cmd_d   = cmd_q;
    end
  end

  always_ff @(posedge clock_i or negedge reset_i)
    if (!reset_i) begin
      state_q <= INICIAL;
      addr_q  <= '0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cmd_q   <= cmd_d;
    end

  assign mem_addr_o    = addr_q;
  assign motor_cmd_o   = cmd_q;
  assign motor_start_o = state_q == DISPARA && !parar_i;
  assign pronto_o      = state_q == FIM;
  assign db_estado_o   = state_q;
endmodule

// File: tb/tb_executa_movimentos.sv
// tb_executa_movimentos: directed self-checking bench for executa_movimentos.
module tb_executa_movimentos;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic       rst_n, parar, ini_a, ini_b, done_a, done_b;
  logic [2:0] dado_a, dado_b, cmd_a, cmd_b;
  logic [5:0] addr_a;
  logic [1:0] addr_b;
  logic       start_a, start_b, pronto_a, pronto_b, erro_a, erro_b;
  logic [3:0] st_a, st_b;
  logic [2:0] mem_a [64];
  logic [2:0] mem_b [4];
  int checks = 0, errors = 0, pronto_cnt_a = 0, start_cnt_a = 0;

  executa_movimentos #(.ADDR_W(6), .TIMEOUT(10)) dut_a (
    .clock_i(clk), .reset_i(rst_n), .iniciar_i(ini_a), .parar_i(parar),
    .mem_dado_i(dado_a), .motor_done_i(done_a), .mem_addr_o(addr_a),
    .motor_cmd_o(cmd_a), .motor_start_o(start_a), .pronto_o(pronto_a),
    .erro_o(erro_a), .db_estado_o(st_a));

  executa_movimentos #(.ADDR_W(2), .TIMEOUT(1000)) dut_b (
    .clock_i(clk), .reset_i(rst_n), .iniciar_i(ini_b), .parar_i(parar),
    .mem_dado_i(dado_b), .motor_done_i(done_b), .mem_addr_o(addr_b),
    .motor_cmd_o(cmd_b), .motor_start_o(start_b), .pronto_o(pronto_b),
    .erro_o(erro_b), .db_estado_o(st_b));

  always @(posedge clk) begin
    dado_a <= mem_a[addr_a];
    dado_b <= mem_b[addr_b];
  end
  always @(posedge clk) if (pronto_a) pronto_cnt_a <= pronto_cnt_a + 1;
  always @(posedge clk) if (start_a) start_cnt_a <= start_cnt_a + 1;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic done_seq_a;
    tick; tick; done_a = 1'b1; tick; done_a = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; parar = 1'b0; ini_a = 1'b0; ini_b = 1'b0; done_a = 1'b0; done_b = 1'b0;
    tick; tick;
    checks++;
    if ({st_a, addr_a, cmd_a, start_a, pronto_a, erro_a} !== 16'd0) begin
      errors++; $display("FAIL reset_a: got %h expected 0", {st_a, addr_a, cmd_a, start_a, pronto_a, erro_a});
    end
    checks++;
    if ({st_b, addr_b, cmd_b, start_b, pronto_b, erro_b} !== 12'd0) begin
      errors++; $display("FAIL reset_b: got %h expected 0", {st_b, addr_b, cmd_b, start_b, pronto_b, erro_b});
    end
    rst_n = 1'b1;
    tick; done_a = 1'b1; tick; done_a = 1'b0; tick;
    checks++;
    if (st_a !== 4'd0) begin errors++; $display("FAIL idle_after_reset: state %0d expected 0", st_a); end
  endtask

  task automatic test_list;
    logic [2:0] ec [3] = '{3'd1, 3'd4, 3'd2};
    int p0 = pronto_cnt_a;
    for (int i = 0; i < 64; i++) mem_a[i] = 3'd7;
    mem_a[0] = 3'd1; mem_a[1] = 3'd4; mem_a[2] = 3'd2; mem_a[3] = 3'd7;
    ini_a = 1'b1; tick; ini_a = 1'b0;
    checks++;
    if (st_a !== 4'd1) begin errors++; $display("FAIL list_zera: state %0d expected 1", st_a); end
    tick; tick; tick;
    checks++;
    if ({st_a, start_a} !== {4'd4, 1'b1}) begin
      errors++; $display("FAIL list_latency: state %0d start %b expected 4 1", st_a, start_a);
    end
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 20 && !start_a; k++) tick;
      checks++;
      if ({start_a, cmd_a, addr_a} !== {1'b1, ec[i], 6'(i)}) begin
        errors++; $display("FAIL list_move%0d: start %b cmd %0d addr %0d expected 1 %0d %0d", i, start_a, cmd_a, addr_a, ec[i], i);
      end
      tick;
      checks++;
      if (start_a !== 1'b0) begin errors++; $display("FAIL list_pulse%0d: start %b expected 0", i, start_a); end
      tick; done_a = 1'b1; tick; done_a = 1'b0;
    end
    for (int k = 0; k < 20 && !pronto_a; k++) tick;
    checks++;
    if ({pronto_a, addr_a} !== {1'b1, 6'd3}) begin
      errors++; $display("FAIL list_pronto: pronto %b addr %0d expected 1 3", pronto_a, addr_a);
    end
    tick;
    checks++;
    if ({st_a, pronto_a, 32'(pronto_cnt_a - p0)} !== {4'd0, 1'b0, 32'd1}) begin
      errors++; $display("FAIL list_end: state %0d pronto %b count %0d expected 0 0 1", st_a, pronto_a, pronto_cnt_a - p0);
    end
  endtask

  task automatic test_end_first;
    int s0 = start_cnt_a;
    mem_a[0] = 3'd7;
    ini_a = 1'b1; tick; ini_a = 1'b0;
    tick; tick; tick;
    checks++;
    if ({st_a, pronto_a} !== {4'd7, 1'b1}) begin
      errors++; $display("FAIL first_end_pronto: state %0d pronto %b expected 7 1", st_a, pronto_a);
    end
    tick;
    checks++;
    if ({st_a, 32'(start_cnt_a - s0)} !== {4'd0, 32'd0}) begin
      errors++; $display("FAIL first_end_nostart: state %0d starts %0d expected 0 0", st_a, start_cnt_a - s0);
    end
  endtask

  task automatic test_no_marker;
    logic [2:0] ec [4] = '{3'd1, 3'd2, 3'd3, 3'd5};
    for (int i = 0; i < 4; i++) mem_b[i] = ec[i];
    ini_b = 1'b1; tick; ini_b = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int k = 0; k < 20 && !start_b; k++) tick;
      checks++;
      if ({start_b, cmd_b, addr_b} !== {1'b1, ec[i], 2'(i)}) begin
        errors++; $display("FAIL nomark_move%0d: start %b cmd %0d addr %0d expected 1 %0d %0d", i, start_b, cmd_b, addr_b, ec[i], i);
      end
      tick; tick; done_b = 1'b1; tick; done_b = 1'b0;
    end
    for (int k = 0; k < 20 && !pronto_b; k++) tick;
    checks++;
    if ({pronto_b, addr_b} !== {1'b1, 2'd3}) begin
      errors++; $display("FAIL nomark_pronto: pronto %b addr %0d expected 1 3", pronto_b, addr_b);
    end
    tick;
    checks++;
    if ({st_b, addr_b} !== {4'd0, 2'd3}) begin
      errors++; $display("FAIL nomark_nowrap: state %0d addr %0d expected 0 3", st_b, addr_b);
    end
  endtask

  task automatic test_parar;
    int p0 = pronto_cnt_a;
    int s0 = start_cnt_a;
    mem_a[0] = 3'd1; mem_a[1] = 3'd4; mem_a[2] = 3'd2; mem_a[3] = 3'd7;
    ini_a = 1'b1; tick; ini_a = 1'b0;
    for (int k = 0; k < 20 && !start_a; k++) tick;
    tick;
    checks++;
    if (st_a !== 4'd5) begin errors++; $display("FAIL parar_espera_reach: state %0d expected 5", st_a); end
    parar = 1'b1; tick; parar = 1'b0;
    checks++;
    if (st_a !== 4'd0) begin errors++; $display("FAIL parar_espera: state %0d expected 0", st_a); end
    ini_a = 1'b1; tick; ini_a = 1'b0;
    tick; tick;
    @(posedge clk); #1 parar = 1'b1;
    #1;
    checks++;
    if ({st_a, start_a} !== {4'd4, 1'b0}) begin
      errors++; $display("FAIL parar_dispara_start: state %0d start %b expected 4 0", st_a, start_a);
    end
    tick; tick; parar = 1'b0;
    checks++;
    if ({st_a, 32'(start_cnt_a - s0), 32'(pronto_cnt_a - p0)} !== {4'd0, 32'd1, 32'd0}) begin
      errors++; $display("FAIL parar_dispara: state %0d starts %0d prontos %0d expected 0 1 0", st_a, start_cnt_a - s0, pronto_cnt_a - p0);
    end
  endtask

  task automatic test_timeout;
    mem_a[0] = 3'd1; mem_a[1] = 3'd1; mem_a[2] = 3'd7;
    ini_a = 1'b1; tick; ini_a = 1'b0;
    for (int k = 0; k < 20 && !start_a; k++) tick;
    done_seq_a;
    for (int k = 0; k < 20 && !start_a; k++) tick;
    checks++;
    if ({start_a, addr_a} !== {1'b1, 6'd1}) begin
      errors++; $display("FAIL to_second_start: start %b addr %0d expected 1 1", start_a, addr_a);
    end
`ifdef EXECUTA_MOVIMENTOS_TIMEOUT_EN
    for (int k = 0; k < 10; k++) tick;
    checks++;
    if ({st_a, erro_a} !== {4'd5, 1'b0}) begin
      errors++; $display("FAIL to_early: state %0d erro %b expected 5 0", st_a, erro_a);
    end
    tick;
    checks++;
    if ({st_a, erro_a} !== {4'd8, 1'b1}) begin
      errors++; $display("FAIL to_expire: state %0d erro %b expected 8 1", st_a, erro_a);
    end
    tick; tick; tick;
    checks++;
    if (erro_a !== 1'b1) begin errors++; $display("FAIL to_hold: erro %b expected 1", erro_a); end
    ini_a = 1'b1; tick; ini_a = 1'b0;
    checks++;
    if ({st_a, erro_a} !== {4'd1, 1'b0}) begin
      errors++; $display("FAIL to_restart: state %0d erro %b expected 1 0", st_a, erro_a);
    end
    tick;
    checks++;
    if ({st_a, addr_a} !== {4'd2, 6'd0}) begin
      errors++; $display("FAIL to_restart_addr: state %0d addr %0d expected 2 0", st_a, addr_a);
    end
`else
    for (int k = 0; k < 20; k++) tick;
    checks++;
    if ({st_a, erro_a} !== {4'd5, 1'b0}) begin
      errors++; $display("FAIL to_disabled: state %0d erro %b expected 5 0", st_a, erro_a);
    end
`endif
    parar = 1'b1; tick; parar = 1'b0;
    checks++;
    if (st_a !== 4'd0) begin errors++; $display("FAIL to_abort: state %0d expected 0", st_a); end
  endtask

  task automatic test_async_reset;
    mem_a[0] = 3'd1; mem_a[1] = 3'd4; mem_a[2] = 3'd7;
    ini_a = 1'b1; tick; ini_a = 1'b0;
    for (int k = 0; k < 20 && !start_a; k++) tick;
    done_seq_a;
    for (int k = 0; k < 20 && !start_a; k++) tick;
    tick;
    checks++;
    if ({st_a, addr_a, cmd_a} !== {4'd5, 6'd1, 3'd4}) begin
      errors++; $display("FAIL areset_setup: state %0d addr %0d cmd %0d expected 5 1 4", st_a, addr_a, cmd_a);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({st_a, addr_a, cmd_a, start_a, pronto_a, erro_a} !== 16'd0) begin
      errors++; $display("FAIL areset_async: got %h expected 0", {st_a, addr_a, cmd_a, start_a, pronto_a, erro_a});
    end
    tick; rst_n = 1'b1; tick; tick;
    checks++;
    if (st_a !== 4'd0) begin errors++; $display("FAIL areset_idle: state %0d expected 0", st_a); end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem_a[i] = 3'd7;
    for (int i = 0; i < 4; i++) mem_b[i] = 3'd7;
    test_reset;
    test_list;
    test_end_first;
    test_no_marker;
    test_parar;
    test_timeout;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
